// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared types and constants for the hazard frame sequencer.
//   - Grid geometry (4 rows x 8 columns of 8x8-pixel cells)
//   - Coordinate width and frame buffer depth
//   - Sequencer state enum and the bounding-box struct
// ---------------------------------------------------------------------------
package hazard_pkg;

    localparam int GRID_ROWS  = 4;
    localparam int GRID_COLS  = 8;
    localparam int COORD_W    = 11;
    localparam int MAX_HAZ    = 16;
    localparam int CELL_H_LG2 = 3;
    localparam int CELL_W_LG2 = 3;
    localparam int CNT_W      = 5;    // holds 0..MAX_HAZ
    localparam int IDX_W      = 4;    // indexes 0..MAX_HAZ-1
    localparam int MASK_W     = GRID_ROWS * GRID_COLS;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SWEEP   = 2'd1,
        DONE    = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0] top;
        logic [COORD_W-1:0] left;
        logic [COORD_W-1:0] bottom;
        logic [COORD_W-1:0] right;
    } box_t;

endpackage

// File: rtl/hazard_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// hazard_frame_sequencer_if
// Box input stream (valid/ready) and grid output stream (valid/ready) plus
// frame status of the hazard frame sequencer.
//   master : upstream/consumer side (drives boxes and out_ready)
//   slave  : sequencer side (drives in_ready, grid, status)
// ---------------------------------------------------------------------------
interface hazard_frame_sequencer_if;
    import hazard_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] in_top;
    logic [COORD_W-1:0] in_left;
    logic [COORD_W-1:0] in_bottom;
    logic [COORD_W-1:0] in_right;
    logic               in_last;
    logic               out_valid;
    logic               out_ready;
    logic [15:0]        vec1;
    logic [15:0]        vec2;
    logic [CNT_W-1:0]   hazard_count;
    logic               overflow;
    logic               busy;

    modport master (
        output in_valid, in_top, in_left, in_bottom, in_right, in_last, out_ready,
        input  in_ready, out_valid, vec1, vec2, hazard_count, overflow, busy
    );

    modport slave (
        input  in_valid, in_top, in_left, in_bottom, in_right, in_last, out_ready,
        output in_ready, out_valid, vec1, vec2, hazard_count, overflow, busy
    );

endinterface

// File: rtl/hazard_cell_mask.sv
// ---------------------------------------------------------------------------
// hazard_cell_mask
// Purely combinational: converts one bounding box into the 32-bit set of grid
// cells it covers. Bit index = row*8 + col (rows 0-1 -> bits 15:0,
// rows 2-3 -> bits 31:16).
//   box_i  : box {top, left, bottom, right} in pixels, inclusive bounds
//   mask_o : covered-cell mask
// ---------------------------------------------------------------------------
module hazard_cell_mask
    import hazard_pkg::*;
(
    input  box_t              box_i,
    output logic [MASK_W-1:0] mask_o
);

    logic [COORD_W-1:0] r_lo_s;
    logic [COORD_W-1:0] r_hi_raw_s;
    logic [COORD_W-1:0] r_hi_s;
    logic [COORD_W-1:0] c_lo_s;
    logic [COORD_W-1:0] c_hi_raw_s;
    logic [COORD_W-1:0] c_hi_s;
    logic               malformed_s;
    logic               off_grid_s;
    logic               keep_s;

    // Derive the clamped cell range and fill the covered cells.
    always_comb begin
        r_lo_s      = box_i.top    >> CELL_H_LG2;
        r_hi_raw_s  = box_i.bottom >> CELL_H_LG2;
        c_lo_s      = box_i.left   >> CELL_W_LG2;
        c_hi_raw_s  = box_i.right  >> CELL_W_LG2;
        r_hi_s      = (r_hi_raw_s > COORD_W'(GRID_ROWS - 1)) ? COORD_W'(GRID_ROWS - 1) : r_hi_raw_s;
        c_hi_s      = (c_hi_raw_s > COORD_W'(GRID_COLS - 1)) ? COORD_W'(GRID_COLS - 1) : c_hi_raw_s;
        malformed_s = (box_i.top > box_i.bottom) || (box_i.left > box_i.right);
        off_grid_s  = (r_lo_s > COORD_W'(GRID_ROWS - 1)) || (c_lo_s > COORD_W'(GRID_COLS - 1));
        keep_s      = !malformed_s && !off_grid_s;
        mask_o      = '0;
        for (int r = 0; r < GRID_ROWS; r++) begin
            for (int c = 0; c < GRID_COLS; c++) begin
                mask_o[r*GRID_COLS + c] = keep_s
                    && (COORD_W'(r) >= r_lo_s) && (COORD_W'(r) <= r_hi_s)
                    && (COORD_W'(c) >= c_lo_s) && (COORD_W'(c) <= c_hi_s);
            end
        end
    end

endmodule

// File: rtl/hazard_frame_sequencer.sv
// ---------------------------------------------------------------------------
// hazard_frame_sequencer
// Collects a frame of up to MAX_HAZ boxes, then sweeps them one per cycle
// through a single shared hazard_cell_mask, ORing into a 4x8 occupancy grid
// that is presented with a valid/ready handshake.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of hazard_frame_sequencer_if (box stream in,
//           grid vec1/vec2 out, hazard_count, overflow, busy)
// ---------------------------------------------------------------------------
module hazard_frame_sequencer
    import hazard_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    hazard_frame_sequencer_if.slave   bus
);

    state_e             state_q, state_d;
    // count_q doubles as the buffer write pointer: boxes are stored densely.
    logic [CNT_W-1:0]   count_q, count_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [MASK_W-1:0]  acc_q,   acc_d;
    logic               ovf_q,   ovf_d;
    box_t               buf_q [MAX_HAZ];

    logic               accept_s;
    logic               wr_en_s;
    box_t               wr_box_s;
    logic [MASK_W-1:0]  mask_s;

    hazard_cell_mask u_cell_mask (
        .box_i  (buf_q[idx_q]),
        .mask_o (mask_s)
    );

    // State and frame registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            idx_q   <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
        end
    end

    // Box buffer: contents are only meaningful below count_q, so no reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            buf_q[count_q[IDX_W-1:0]] <= wr_box_s;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        wr_en_s  = 1'b0;
        wr_box_s = '{top: bus.in_top, left: bus.in_left,
                     bottom: bus.in_bottom, right: bus.in_right};
        accept_s = bus.in_valid && (state_q == COLLECT);
        case (state_q)
            COLLECT: begin
                if (accept_s) begin
                    if (count_q < CNT_W'(MAX_HAZ)) begin
                        wr_en_s = 1'b1;
                        count_d = count_q + 5'd1;
                    end else begin
                        // Frame is full: drop the beat but remember it.
                        ovf_d = 1'b1;
                    end
                    if (bus.in_last) begin
                        state_d = SWEEP;
                        idx_d   = '0;
                    end else begin
                        state_d = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            SWEEP: begin
                acc_d = acc_q | mask_s;
                idx_d = idx_q + 4'd1;
                // '>=' rather than '==' so a corrupted index cannot loop forever.
                if (({1'b0, idx_q} + 5'd1) >= count_q) begin
                    state_d = DONE;
                end else begin
                    state_d = SWEEP;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = COLLECT;
                    count_d = '0;
                    idx_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = COLLECT;
                count_d = '0;
                idx_d   = '0;
                acc_d   = '0;
                ovf_d   = 1'b0;
            end
        endcase
    end

    // Output decode from the registered state; grid is only exposed in DONE.
    always_comb begin
        bus.hazard_count = count_q;
        bus.overflow     = ovf_q;
        case (state_q)
            COLLECT: begin
                bus.in_ready  = 1'b1;
                bus.out_valid = 1'b0;
                bus.busy      = 1'b0;
                bus.vec1      = 16'h0000;
                bus.vec2      = 16'h0000;
            end
            SWEEP: begin
                bus.in_ready  = 1'b0;
                bus.out_valid = 1'b0;
                bus.busy      = 1'b1;
                bus.vec1      = 16'h0000;
                bus.vec2      = 16'h0000;
            end
            DONE: begin
                bus.in_ready  = 1'b0;
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
                bus.vec1      = acc_q[15:0];
                bus.vec2      = acc_q[31:16];
            end
            default: begin
                bus.in_ready  = 1'b0;
                bus.out_valid = 1'b0;
                bus.busy      = 1'b0;
                bus.vec1      = 16'h0000;
                bus.vec2      = 16'h0000;
            end
        endcase
    end

endmodule
